keccak_pad_blk: RTL and testbench

- Upstream feeder for the Keccak permutation block. It accepts a message as a byte stream and packs the bytes little-endian into 64-bit lanes.
- Applies SHA3 padding (pad byte, then 0x80 in the final rate byte), zero-fills the capacity lanes, and emits each 1600-bit block as 25 lanes on the same push/stop/first lane handshake the permutation consumes.
- Buffers one full rate block, because emission order (x outer, y inner) differs from message lane order (i = x+5y).

---
 rtl/keccak_pkg.sv | 18 +
 rtl/keccak_pad_blk.sv | 128 ++++++++++++
 tb/tb_keccak_pad_blk.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared types and helpers for the Keccak padding/lane feeder.
package keccak_pkg;

  typedef logic [63:0] lane_t;

  localparam int unsigned LANES          = 25;
  localparam int unsigned RATE_LANES_DEF = 17;

  typedef enum logic [1:0] {IDLE, FILL, PAD, EMIT} state_t;

  // Beat k carries lane (x, y) = (k/5, k%5), stored in message order at x+5y.
  function automatic int unsigned beat_to_lane(input logic [4:0] k);
    int unsigned kk;
    kk = int'(k);
    return (kk / 5) + 5 * (kk % 5);
  endfunction

endpackage

// File: rtl/keccak_pad_blk.sv
// Packs a byte stream into 64-bit lanes, applies SHA3 padding and emits
// 25-lane blocks in permutation (x outer, y inner) order.
module keccak_pad_blk
  import keccak_pkg::*;
#(
  parameter int unsigned RATE_LANES = RATE_LANES_DEF,
  parameter logic [7:0]  PAD_BYTE   = 8'h06
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  output logic        stopin,
  input  logic        firstin,
  input  logic        lastin,
  input  logic [7:0]  din,
  output logic        pushout,
  input  logic        stopout,
  output logic        firstout,
  output logic        lastout,
  output lane_t       dout
);

  localparam int unsigned RATE_BYTES = 8 * RATE_LANES;
  localparam int unsigned BW         = 8 * RATE_BYTES;
  localparam int unsigned CW         = $clog2(RATE_BYTES + 1);

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      beat_q, beat_d;
  logic            pend_q, pend_d;
  logic            final_q, final_d;
  logic [CW-1:0]   pos;
  logic            accept;
  int unsigned     lane;

  assign accept = pushin && !stopin;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    pend_d  = pend_q;
    final_d = final_q;
    pos     = cnt_q;
    unique case (state_q)
      IDLE, FILL: begin
        // In IDLE only a firstin byte starts a message; in FILL firstin restarts it.
        if (accept && (firstin || state_q == FILL)) begin
          if (firstin) begin
            buf_d = '0;
            pos   = '0;
          end
          buf_d[int'(pos)*8 +: 8] = din;
          cnt_d = pos + 1'b1;
          if (pos == CW'(RATE_BYTES - 1)) begin
            state_d = EMIT;
            beat_d  = '0;
            pend_d  = lastin;
          end else if (lastin) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      PAD: begin
        buf_d[int'(cnt_q)*8 +: 8] = buf_d[int'(cnt_q)*8 +: 8] | PAD_BYTE;
        buf_d[BW-8 +: 8]          = buf_d[BW-8 +: 8] | 8'h80;
        final_d = 1'b1;
        beat_d  = '0;
        state_d = EMIT;
      end
      EMIT: begin
        if (!stopout) begin
          if (beat_q == 5'(LANES - 1)) begin
            buf_d   = '0;
            cnt_d   = '0;
            beat_d  = '0;
            final_d = 1'b0;
            if (pend_q) begin
              pend_d  = 1'b0;
              state_d = PAD;
            end else if (final_q) begin
              state_d = IDLE;
            end else begin
              state_d = FILL;
            end
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
      final_q <= final_d;
    end
  end

  assign stopin   = (state_q == PAD) || (state_q == EMIT);
  assign pushout  = (state_q == EMIT);
  assign firstout = pushout && (beat_q == 5'd0);
  assign lastout  = pushout && final_q && (beat_q == 5'(LANES - 1));

  always_comb begin
    lane = beat_to_lane(beat_q);
    dout = '0;
    if (pushout && lane < RATE_LANES) dout = buf_q[lane*64 +: 64];
  end

endmodule

// File: tb/tb_keccak_pad_blk.sv
// Randomised self-checking bench for keccak_pad_blk against a padded-message model.
module tb_keccak_pad_blk;

  localparam int unsigned RL = 17;
  localparam int unsigned RB = 8 * RL;
  localparam logic [7:0]  PB = 8'h06;

  typedef struct {
    logic [63:0] d;
    bit          f;
    bit          l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pushin = 1'b0, firstin = 1'b0, lastin = 1'b0, stopout = 1'b0;
  logic [7:0]  din = '0;
  logic        stopin, pushout, firstout, lastout;
  logic [63:0] dout;

  int    n_chk = 0, n_fail = 0;
  beat_t exp_q[$];
  int    blk_beat = 0;
  bit    rnd_stall = 0, stall3 = 0, rnd_gap = 0;
  int    stall_cnt = 0;

  keccak_pad_blk #(.RATE_LANES(RL), .PAD_BYTE(PB)) dut (
    .clk(clk), .rst(rst), .pushin(pushin), .stopin(stopin), .firstin(firstin),
    .lastin(lastin), .din(din), .pushout(pushout), .stopout(stopout),
    .firstout(firstout), .lastout(lastout), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: pad the whole message, split into rate blocks, emit x-outer/y-inner.
  task automatic model_msg(input logic [7:0] msg[$]);
    int unsigned len = msg.size();
    int unsigned nblk = len / RB + 1;
    bit [7:0] p[];
    p = new[nblk * RB];
    foreach (p[i]) p[i] = 8'h00;
    foreach (msg[i]) p[i] = msg[i];
    p[len] = p[len] | PB;
    p[nblk*RB - 1] = p[nblk*RB - 1] | 8'h80;
    for (int unsigned b = 0; b < nblk; b++) begin
      for (int unsigned k = 0; k < 25; k++) begin
        beat_t e;
        int unsigned li = (k / 5) + 5 * (k % 5);
        e.d = '0;
        if (li < RL) for (int j = 7; j >= 0; j--) e.d = {e.d[55:0], p[b*RB + li*8 + j]};
        e.f = (k == 0);
        e.l = (k == 24) && (b == nblk - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_raw(input logic [7:0] b, input bit f, input bit l);
    int n = 0;
    if (rnd_gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    while (stopin && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq("stopin_timeout", 64'(stopin), 64'd0);
    pushin = 1'b1; din = b; firstin = f; lastin = l;
    @(posedge clk);
    #1;
    pushin = 1'b0; firstin = 1'b0; lastin = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] msg[$]);
    model_msg(msg);
    foreach (msg[i]) send_raw(msg[i], i == 0, i == msg.size() - 1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Output monitor: lanes handed over on negedges where pushout && !stopout.
  logic [63:0] prev_dout = '0;
  bit          prev_stall = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      blk_beat   = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_dout", dout, prev_dout);
        check_eq("hold_push", 64'(pushout), 64'd1);
      end
      if (pushout) check_eq("stopin_emit", 64'(stopin), 64'd1);
      if (pushout && !stopout) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 64'(pushout), 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check_eq("dout", dout, e.d);
          check_eq("first_last", 64'({firstout, lastout}), 64'({e.f, e.l}));
        end
        blk_beat = (blk_beat == 24) ? 0 : blk_beat + 1;
      end
      prev_stall = pushout && stopout;
      prev_dout  = dout;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (stall3 && blk_beat == 3 && stall_cnt < 4) begin
      stopout = 1'b1;
      stall_cnt++;
    end else begin
      stopout = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] abc[$];
    logic [7:0] m[$];
    int n;
    abc = '{8'h61, 8'h62, 8'h63};

    #2;
    check_eq("rst_pushout", 64'(pushout), 64'd0);
    check_eq("rst_stopin", 64'(stopin), 64'd0);
    check_eq("rst_dout", dout, 64'd0);
    check_eq("rst_flags", 64'({firstout, lastout}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // "abc" plus latency: PAD cycle, then first lane.
    send_msg(abc);
    @(negedge clk);
    check_eq("lat_pad_push", 64'(pushout), 64'd0);
    check_eq("lat_pad_stop", 64'(stopin), 64'd1);
    @(negedge clk);
    check_eq("lat_emit_push", 64'(pushout), 64'd1);
    wait_drain(200);

    m.delete();
    repeat (136) m.push_back(8'h00);
    send_msg(m);
    wait_drain(400);

    m.delete();
    repeat (135) m.push_back(8'hFF);
    send_msg(m);
    wait_drain(400);

    stall_cnt = 0;
    stall3 = 1;
    send_msg(abc);
    wait_drain(200);
    stall3 = 0;

    // Asynchronous reset in the middle of a block.
    model_msg(abc);
    foreach (abc[i]) send_raw(abc[i], i == 0, i == 2);
    n = 0;
    while (blk_beat != 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_beat10", 64'(blk_beat), 64'd10);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_push", 64'(pushout), 64'd0);
    check_eq("async_rst_stopin", 64'(stopin), 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    send_msg(abc);
    wait_drain(200);

    // Stray bytes are dropped in IDLE; a new firstin discards a partial message.
    send_raw(8'h11, 1'b0, 1'b0);
    send_raw(8'h22, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_raw(8'(8'hA0 + i), i == 0, 1'b0);
    model_msg(abc);
    foreach (abc[i]) send_raw(abc[i], i == 0, i == 2);
    wait_drain(200);

    rnd_stall = 1;
    rnd_gap   = 1;
    for (int t = 0; t < 6; t++) begin
      m.delete();
      n = (t == 0) ? 272 : $urandom_range(1, 300);
      repeat (n) m.push_back(8'($urandom));
      send_msg(m);
      wait_drain(3000);
    end
    rnd_stall = 0;
    rnd_gap   = 0;
    @(negedge clk);
    check_eq("idle_pushout", 64'(pushout), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
